// File: rtl/mc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle control sequencer:
//   - state_t    : 4-bit FSM state encoding (also visible on the debug port)
//   - OP_*       : instruction opcode values
//   - ALU_*, SRCA_*, SRCB_*, PC_*, M2R_*, RD_* : datapath select encodings
//   - ctrl_t     : bundle of every datapath control the sequencer drives
//   - ctrl_of()  : Moore decode from a state to its control bundle
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_RWB      = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_IWB      = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_IN_WB    = 4'd12,
        ST_OUT_WR   = 4'd13,
        ST_HALT     = 4'd14,
        ST_FAULT    = 4'd15
    } state_t;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_J    = 4'd6;
    localparam logic [3:0] OP_IN   = 4'd7;
    localparam logic [3:0] OP_OUT  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B   = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_ALUOUT = 2'd2;

    localparam logic [1:0] M2R_MDR    = 2'd0;
    localparam logic [1:0] M2R_ALUOUT = 2'd1;
    localparam logic [1:0] M2R_IN     = 2'd2;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_R3 = 2'd2;

    // 'fetch' marks the instruction-fetch state: IR/PC writes there are
    // qualified by the live mem_ready, so they are not part of the bundle.
    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       mem_src;
        logic       fetch;
        logic       pc_write;
        logic       reg_write;
        logic       out_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dest;
        logic       halted;
    } ctrl_t;

    // Moore decode: every control not named for a state stays 0.
    function automatic ctrl_t ctrl_of(input state_t s, input logic is_bne);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
                c.fetch    = 1'b1;
            end
            ST_DECODE: begin
                c.src_a  = SRCA_PC;
                c.src_b  = SRCB_IMM;
                c.alu_op = ALU_ADD;
            end
            ST_EXEC_R: begin
                c.src_a  = SRCA_A;
                c.src_b  = SRCB_B;
                c.alu_op = ALU_FUNCT;
            end
            ST_RWB: begin
                c.reg_write  = 1'b1;
                c.reg_dest   = RD_RD;
                c.mem_to_reg = M2R_ALUOUT;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                c.src_a  = SRCA_A;
                c.src_b  = SRCB_IMM;
                c.alu_op = ALU_ADD;
            end
            ST_IWB: begin
                c.reg_write  = 1'b1;
                c.reg_dest   = RD_RT;
                c.mem_to_reg = M2R_ALUOUT;
            end
            ST_MEM_RD: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
                c.mem_src  = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dest   = RD_RT;
                c.mem_to_reg = M2R_MDR;
            end
            ST_MEM_WR: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.mem_src   = 1'b1;
            end
            ST_BRANCH: begin
                c.src_a     = SRCA_A;
                c.src_b     = SRCB_B;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PC_ALUOUT;
                c.branch_eq = ~is_bne;
                c.branch_ne = is_bne;
            end
            ST_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PC_JUMP;
            end
            ST_IN_WB: begin
                c.reg_write  = 1'b1;
                c.reg_dest   = RD_R3;
                c.mem_to_reg = M2R_IN;
            end
            ST_OUT_WR: begin
                c.out_write = 1'b1;
            end
            ST_HALT, ST_FAULT: begin
                c.halted = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mc_sequencer_if
// Memory handshake between the sequencer (master) and the memory (slave).
//   mem_req   : access in progress, held until mem_ready or timeout
//   mem_read  : read qualifier, valid with mem_req
//   mem_write : write qualifier, valid with mem_req
//   mem_src   : address select, 0 = PC, 1 = ALUOut
//   mem_ready : memory completes the current access this cycle
// ---------------------------------------------------------------------------
interface mc_sequencer_if;

    logic mem_req;
    logic mem_read;
    logic mem_write;
    logic mem_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_read,
        output mem_write,
        output mem_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_read,
        input  mem_write,
        input  mem_src,
        output mem_ready
    );

endinterface

// File: rtl/mc_sequencer_mem_waiter.sv
// ---------------------------------------------------------------------------
// mc_mem_waiter
// Wait-state counter and timeout compare for one memory access.
//   clock, reset : clock and asynchronous active-high reset
//   mem_req      : an access is being requested this cycle
//   mem_ready    : memory completes the access this cycle
//   start        : first cycle of a new access; discards the old count
//   done         : access completes this cycle (mem_ready wins over timeout)
//   timeout      : this is the MEM_TIMEOUT-th cycle without mem_ready
// ---------------------------------------------------------------------------
module mc_mem_waiter #(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic mem_req,
    input  logic mem_ready,
    input  logic start,
    output logic done,
    output logic timeout
);

    localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] CAP       = TMO_W'(MEM_TIMEOUT);

    logic [TMO_W-1:0] count;
    logic [TMO_W-1:0] count_eff;
    logic             waiting;

    // The start cycle already counts as a wait cycle, so the old count is
    // dropped combinationally rather than one cycle late.
    assign count_eff = start ? '0 : count;
    assign waiting   = mem_req & ~mem_ready;
    assign done      = mem_req & mem_ready;
    assign timeout   = waiting & (count_eff == LAST_WAIT);

    // Count wait cycles, saturating so the counter can never wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (waiting && (count_eff != CAP)) begin
            count <= count_eff + 1'b1;
        end else begin
            count <= count_eff;
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
// Multicycle control sequencer for the 16-bit register CPU. Walks each
// instruction through FETCH/DECODE/execute states, handshakes memory through
// mc_sequencer_if with wait states and a timeout fault, and drives the
// datapath selects and write enables as a Moore decode of the state.
//
// Ports:
//   clock, reset  : clock, asynchronous active-high reset (back to FETCH)
//   step          : single-step pulse (only with MC_SEQUENCER_SINGLE_STEP_EN)
//   opcode        : IR opcode field, valid from DECODE onward
//   mem           : memory handshake, master side
//   ir_write, pc_write, reg_write, out_write : write enables
//   branch_eq, branch_ne : conditional PC-write qualifiers
//   src_a, src_b, alu_op, pc_src, mem_to_reg, reg_dest : datapath selects
//   state         : current state (debug)
//   fault         : sticky, illegal opcode or memory timeout
//   halted        : high in HALT or FAULT
//
// Build option: define MC_SEQUENCER_SINGLE_STEP_EN to add the step input.
// FETCH is then parked (mem_req low) on entry until step is seen high.
// ---------------------------------------------------------------------------
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int FUNCT_W     = 3,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [OP_W-1:0] opcode,
    mc_sequencer_if.master  mem,
    output logic            ir_write,
    output logic            pc_write,
    output logic            reg_write,
    output logic            out_write,
    output logic            branch_eq,
    output logic            branch_ne,
    output logic            src_a,
    output logic [1:0]      src_b,
    output logic [2:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic [1:0]      mem_to_reg,
    output logic [1:0]      reg_dest,
    output logic [3:0]      state,
    output logic            fault,
    output logic            halted
);

    // Refuse to elaborate with settings the timeout logic cannot honour.
    if (FUNCT_W < 1 || MEM_TIMEOUT < 1 || MEM_TIMEOUT >= (1 << TMO_W)) begin : g_bad_param
        $error("mc_sequencer: invalid FUNCT_W/TMO_W/MEM_TIMEOUT");
    end

    state_t cur_state;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl_nxt;
    ctrl_t  ctrl_rst;
    logic   fault_set;
    logic   mem_start;
    logic   mem_start_nxt;
    logic   mem_done;
    logic   mem_timeout;
    logic   fetch_go;

`ifdef MC_SEQUENCER_SINGLE_STEP_EN
    // The step pre-state is FETCH with this hold flag set, so the state
    // encoding stays at the sixteen 4-bit values.
    logic   park;
    logic   park_nxt;
`endif

    mc_mem_waiter #(
        .TMO_W      (TMO_W),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_waiter (
        .clock    (clock),
        .reset    (reset),
        .mem_req  (ctrl_q.mem_req),
        .mem_ready(mem.mem_ready),
        .start    (mem_start),
        .done     (mem_done),
        .timeout  (mem_timeout)
    );

    // Reset lands in FETCH; with single-step the request stays parked.
    always_comb begin
        ctrl_rst = ctrl_of(ST_FETCH, 1'b0);
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
        ctrl_rst.mem_req  = 1'b0;
        ctrl_rst.mem_read = 1'b0;
`endif
    end

    // Next-state logic, plus the control bundle for the next state so the
    // outputs can be registered alongside the state itself.
    always_comb begin
        state_nxt = cur_state;
        fault_set = 1'b0;
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
        park_nxt  = park;
`endif
        case (cur_state)
            ST_FETCH: begin
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
                if (park) begin
                    if (step) begin
                        park_nxt = 1'b0;
                    end
                end else
`endif
                if (mem_done) begin
                    state_nxt = ST_DECODE;
                end else if (mem_timeout) begin
                    state_nxt = ST_FAULT;
                    fault_set = 1'b1;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_W'(OP_R):    state_nxt = ST_EXEC_R;
                    OP_W'(OP_ADDI): state_nxt = ST_EXEC_I;
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):   state_nxt = ST_MEM_ADDR;
                    OP_W'(OP_BEQ),
                    OP_W'(OP_BNE):  state_nxt = ST_BRANCH;
                    OP_W'(OP_J):    state_nxt = ST_JUMP;
                    OP_W'(OP_IN):   state_nxt = ST_IN_WB;
                    OP_W'(OP_OUT):  state_nxt = ST_OUT_WR;
                    OP_W'(OP_HALT): state_nxt = ST_HALT;
                    default: begin
                        state_nxt = ST_FAULT;
                        fault_set = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R:   state_nxt = ST_RWB;
            ST_EXEC_I:   state_nxt = ST_IWB;
            ST_MEM_ADDR: state_nxt = (opcode == OP_W'(OP_SW)) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_done) begin
                    state_nxt = ST_MEM_WB;
                end else if (mem_timeout) begin
                    state_nxt = ST_FAULT;
                    fault_set = 1'b1;
                end
            end
            ST_MEM_WR: begin
                if (mem_done) begin
                    state_nxt = ST_FETCH;
                end else if (mem_timeout) begin
                    state_nxt = ST_FAULT;
                    fault_set = 1'b1;
                end
            end
            ST_RWB, ST_IWB, ST_MEM_WB, ST_BRANCH,
            ST_JUMP, ST_IN_WB, ST_OUT_WR: state_nxt = ST_FETCH;
            ST_HALT, ST_FAULT:            state_nxt = cur_state;
            default:                      state_nxt = ST_FAULT;
        endcase

`ifdef MC_SEQUENCER_SINGLE_STEP_EN
        if (state_nxt == ST_FETCH && cur_state != ST_FETCH) begin
            park_nxt = 1'b1;
        end
`endif

        mem_start_nxt = (state_nxt != cur_state) &&
                        (state_nxt == ST_FETCH || state_nxt == ST_MEM_RD ||
                         state_nxt == ST_MEM_WR);

        ctrl_nxt = ctrl_of(state_nxt, opcode == OP_W'(OP_BNE));
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
        if (park_nxt) begin
            ctrl_nxt.mem_req  = 1'b0;
            ctrl_nxt.mem_read = 1'b0;
        end
`endif
    end

    // State register with registered Moore outputs; fault only ever sets
    // and is cleared solely by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= ST_FETCH;
            ctrl_q    <= ctrl_rst;
            fault     <= 1'b0;
            mem_start <= 1'b1;
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
            park      <= 1'b1;
`endif
        end else begin
            cur_state <= state_nxt;
            ctrl_q    <= ctrl_nxt;
            fault     <= fault | fault_set;
            mem_start <= mem_start_nxt;
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
            park      <= park_nxt;
`endif
        end
    end

    // IR/PC write-back of the fetch only happens on the cycle memory answers.
    assign fetch_go = ctrl_q.fetch & ctrl_q.mem_req & mem.mem_ready;

    assign mem.mem_req   = ctrl_q.mem_req;
    assign mem.mem_read  = ctrl_q.mem_read;
    assign mem.mem_write = ctrl_q.mem_write;
    assign mem.mem_src   = ctrl_q.mem_src;

    assign ir_write   = fetch_go;
    assign pc_write   = ctrl_q.pc_write | fetch_go;
    assign reg_write  = ctrl_q.reg_write;
    assign out_write  = ctrl_q.out_write;
    assign branch_eq  = ctrl_q.branch_eq;
    assign branch_ne  = ctrl_q.branch_ne;
    assign src_a      = ctrl_q.src_a;
    assign src_b      = fetch_go ? SRCB_ONE : ctrl_q.src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign pc_src     = ctrl_q.pc_src;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign reg_dest   = ctrl_q.reg_dest;
    assign state      = cur_state;
    assign halted     = ctrl_q.halted;

endmodule

// File: tb/tb_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_sequencer
// Directed-vector bench for mc_sequencer with hand-computed expectations.
// Inputs change 1 time unit after the rising edge and outputs are sampled
// 2 units after it. Build option MC_SEQUENCER_SINGLE_STEP_EN selects the
// single-step sequence instead of the default one.
// ---------------------------------------------------------------------------
module tb_mc_sequencer;
    import mc_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
    logic       step;
`endif
    logic       ir_write, pc_write, reg_write, out_write;
    logic       branch_eq, branch_ne, src_a;
    logic [1:0] src_b, pc_src, mem_to_reg, reg_dest;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       fault, halted;

    int vectors     = 0;
    int miscompares = 0;
    int irPulses    = 0;

    mc_sequencer_if memBus();

    mc_sequencer #(
        .OP_W       (4),
        .FUNCT_W    (3),
        .TMO_W      (4),
        .MEM_TIMEOUT(15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
        .step      (step),
`endif
        .opcode    (opcode),
        .mem       (memBus),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .out_write (out_write),
        .branch_eq (branch_eq),
        .branch_ne (branch_ne),
        .src_a     (src_a),
        .src_b     (src_b),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .mem_to_reg(mem_to_reg),
        .reg_dest  (reg_dest),
        .state     (state),
        .fault     (fault),
        .halted    (halted)
    );

    // 10-unit clock period
    always #5 clock = ~clock;

    // Single comparison point: counts every vector and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive opcode and mem_ready, then let combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] op, input logic rdy);
        opcode           = op;
        memBus.mem_ready = rdy;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Fetch with zero wait, then one DECODE cycle; leaves the bench at the
    // start of the first execute cycle.
    task automatic fetchDecode(input logic [3:0] op, input string tag);
        applyStimulus(op, 1'b1);
        checkOutput({tag, "_fetch_state"}, 32'(state), 32'(ST_FETCH));
        checkOutput({tag, "_ir_write"}, 32'(ir_write), 1);
        nextCycle();
        applyStimulus(op, 1'b0);
        checkOutput({tag, "_decode_state"}, 32'(state), 32'(ST_DECODE));
        nextCycle();
    endtask

    // Reset pulse away from the edge, leaving mem_ready low.
    task automatic pulseReset();
        memBus.mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        nextCycle();
    endtask

    // Global bound so a stuck run still terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] addStates [4];
        logic       addRegWr  [4];
        addStates = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_RWB};
        addRegWr  = '{1'b0, 1'b0, 1'b0, 1'b1};

        reset            = 1'b1;
        opcode           = 4'd0;
        memBus.mem_ready = 1'b0;
`ifdef MC_SEQUENCER_SINGLE_STEP_EN
        step             = 1'b0;
`endif
        #2;

`ifdef MC_SEQUENCER_SINGLE_STEP_EN
        checkOutput("rst_state", 32'(state), 32'(ST_FETCH));
        checkOutput("rst_mem_req_parked", 32'(memBus.mem_req), 0);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            applyStimulus(OP_R, 1'b1);
            checkOutput("park_state", 32'(state), 32'(ST_FETCH));
            checkOutput("park_mem_req", 32'(memBus.mem_req), 0);
            checkOutput("park_ir_write", 32'(ir_write), 0);
        end
        step = 1'b1;
        nextCycle();
        step = 1'b0;
        applyStimulus(OP_R, 1'b1);
        checkOutput("step_mem_req", 32'(memBus.mem_req), 1);
        checkOutput("step_ir_write", 32'(ir_write), 1);
        nextCycle();
        checkOutput("step_decode", 32'(state), 32'(ST_DECODE));
        nextCycle();
        nextCycle();
        checkOutput("step_rwb", 32'(state), 32'(ST_RWB));
        nextCycle();
        applyStimulus(OP_R, 1'b1);
        checkOutput("step_reparked_state", 32'(state), 32'(ST_FETCH));
        checkOutput("step_reparked_req", 32'(memBus.mem_req), 0);
`else
        // Reset state
        checkOutput("rst_state", 32'(state), 32'(ST_FETCH));
        checkOutput("rst_fault", 32'(fault), 0);
        checkOutput("rst_mem_req", 32'(memBus.mem_req), 1);
        checkOutput("rst_mem_read", 32'(memBus.mem_read), 1);
        checkOutput("rst_pc_write", 32'(pc_write), 0);
        checkOutput("rst_reg_write", 32'(reg_write), 0);
        checkOutput("rst_src_b", 32'(src_b), 0);
        checkOutput("rst_halted", 32'(halted), 0);
        reset = 1'b0;
        nextCycle();

        // ADD with zero-wait memory: four cycles, write-back on the last
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_R, 1'b1);
            checkOutput("add_state", 32'(state), 32'(addStates[i]));
            checkOutput("add_reg_write", 32'(reg_write), 32'(addRegWr[i]));
            if (i == 0) checkOutput("add_fetch_src_b", 32'(src_b), 1);
            if (i == 2) checkOutput("add_exec_alu_op", 32'(alu_op), 2);
            if (i == 3) checkOutput("add_rwb_reg_dest", 32'(reg_dest), 1);
            nextCycle();
        end
        applyStimulus(OP_R, 1'b0);
        checkOutput("add_back_to_fetch", 32'(state), 32'(ST_FETCH));

        // LW with three wait states in FETCH and in MEM_RD
        for (int c = 0; c < 4; c++) begin
            applyStimulus(OP_LW, c == 3);
            checkOutput("lw_fetch_state", 32'(state), 32'(ST_FETCH));
            irPulses += int'(ir_write);
            nextCycle();
        end
        applyStimulus(OP_LW, 1'b0);
        checkOutput("lw_decode_state", 32'(state), 32'(ST_DECODE));
        irPulses += int'(ir_write);
        nextCycle();
        applyStimulus(OP_LW, 1'b0);
        checkOutput("lw_addr_state", 32'(state), 32'(ST_MEM_ADDR));
        checkOutput("lw_addr_src_b", 32'(src_b), 2);
        irPulses += int'(ir_write);
        nextCycle();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(OP_LW, c == 3);
            checkOutput("lw_rd_state", 32'(state), 32'(ST_MEM_RD));
            checkOutput("lw_rd_mem_src", 32'(memBus.mem_src), 1);
            checkOutput("lw_rd_mem_read", 32'(memBus.mem_read), 1);
            irPulses += int'(ir_write);
            nextCycle();
        end
        applyStimulus(OP_LW, 1'b0);
        checkOutput("lw_wb_state", 32'(state), 32'(ST_MEM_WB));
        checkOutput("lw_wb_reg_write", 32'(reg_write), 1);
        checkOutput("lw_wb_mem_to_reg", 32'(mem_to_reg), 0);
        checkOutput("lw_ir_pulses", 32'(irPulses), 1);
        nextCycle();

        // BEQ / BNE
        fetchDecode(OP_BEQ, "beq");
        applyStimulus(OP_BEQ, 1'b0);
        checkOutput("beq_state", 32'(state), 32'(ST_BRANCH));
        checkOutput("beq_branch_eq", 32'(branch_eq), 1);
        checkOutput("beq_branch_ne", 32'(branch_ne), 0);
        checkOutput("beq_alu_op", 32'(alu_op), 1);
        checkOutput("beq_pc_src", 32'(pc_src), 2);
        nextCycle();
        fetchDecode(OP_BNE, "bne");
        applyStimulus(OP_BNE, 1'b0);
        checkOutput("bne_branch_eq", 32'(branch_eq), 0);
        checkOutput("bne_branch_ne", 32'(branch_ne), 1);
        checkOutput("bne_alu_op", 32'(alu_op), 1);
        nextCycle();

        // J, IN, OUT, ADDI
        fetchDecode(OP_J, "j");
        checkOutput("j_pc_write", 32'(pc_write), 1);
        checkOutput("j_pc_src", 32'(pc_src), 1);
        nextCycle();
        fetchDecode(OP_IN, "in");
        checkOutput("in_reg_dest", 32'(reg_dest), 2);
        checkOutput("in_mem_to_reg", 32'(mem_to_reg), 2);
        nextCycle();
        fetchDecode(OP_OUT, "out");
        checkOutput("out_out_write", 32'(out_write), 1);
        nextCycle();
        fetchDecode(OP_ADDI, "addi");
        checkOutput("addi_exec_state", 32'(state), 32'(ST_EXEC_I));
        nextCycle();
        checkOutput("addi_wb_reg_write", 32'(reg_write), 1);
        checkOutput("addi_wb_reg_dest", 32'(reg_dest), 0);
        checkOutput("addi_wb_mem_to_reg", 32'(mem_to_reg), 1);
        nextCycle();

        // SW answered on the 15th wait cycle: mem_ready wins
        fetchDecode(OP_SW, "sw_edge");
        nextCycle();
        for (int c = 1; c <= 15; c++) begin
            applyStimulus(OP_SW, c == 15);
            checkOutput("sw_edge_state", 32'(state), 32'(ST_MEM_WR));
            nextCycle();
        end
        applyStimulus(OP_SW, 1'b0);
        checkOutput("sw_edge_back_fetch", 32'(state), 32'(ST_FETCH));
        checkOutput("sw_edge_fault", 32'(fault), 0);

        // SW never answered: FAULT after 15 wait cycles
        fetchDecode(OP_SW, "sw_tmo");
        nextCycle();
        for (int c = 1; c <= 15; c++) begin
            applyStimulus(OP_SW, 1'b0);
            checkOutput("sw_tmo_state", 32'(state), 32'(ST_MEM_WR));
            checkOutput("sw_tmo_mem_write", 32'(memBus.mem_write), 1);
            nextCycle();
        end
        applyStimulus(OP_SW, 1'b0);
        checkOutput("sw_tmo_fault_state", 32'(state), 32'(ST_FAULT));
        checkOutput("sw_tmo_fault", 32'(fault), 1);
        checkOutput("sw_tmo_halted", 32'(halted), 1);
        checkOutput("sw_tmo_mem_req", 32'(memBus.mem_req), 0);
        pulseReset();

        // Reset in the middle of MEM_RD
        fetchDecode(OP_LW, "rst_mid");
        nextCycle();
        applyStimulus(OP_LW, 1'b0);
        checkOutput("rst_mid_rd_state", 32'(state), 32'(ST_MEM_RD));
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_state", 32'(state), 32'(ST_FETCH));
        checkOutput("rst_mid_fault", 32'(fault), 0);
        checkOutput("rst_mid_mem_req", 32'(memBus.mem_req), 1);
        checkOutput("rst_mid_mem_src", 32'(memBus.mem_src), 0);
        checkOutput("rst_mid_reg_write", 32'(reg_write), 0);
        checkOutput("rst_mid_ir_write", 32'(ir_write), 0);
        reset = 1'b0;
        nextCycle();

        // Illegal opcode 0xB: FAULT, sticky
        fetchDecode(4'hB, "ill");
        applyStimulus(4'hB, 1'b0);
        checkOutput("ill_state", 32'(state), 32'(ST_FAULT));
        checkOutput("ill_fault", 32'(fault), 1);
        checkOutput("ill_halted", 32'(halted), 1);
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            applyStimulus(OP_R, c[0]);
            checkOutput("ill_sticky_state", 32'(state), 32'(ST_FAULT));
            checkOutput("ill_sticky_fault", 32'(fault), 1);
            checkOutput("ill_sticky_ir_write", 32'(ir_write), 0);
        end
        pulseReset();

        // HALT: absorbing, no fault
        fetchDecode(OP_HALT, "halt");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(OP_HALT, 1'b1);
            checkOutput("halt_state", 32'(state), 32'(ST_HALT));
            checkOutput("halt_fault", 32'(fault), 0);
            checkOutput("halt_halted", 32'(halted), 1);
            checkOutput("halt_mem_req", 32'(memBus.mem_req), 0);
            nextCycle();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Parametrised multicycle control sequencer for the 16-bit accumulator-less register CPU. It replaces the fixed-timing control unit. Memory accesses use a req/ready handshake with wait states and a timeout fault. It drives the same datapath select/enable set (PC, IR, register file, ALU muxes, output register) from the instruction opcode and funct fields.

Parameters:
OP_W, 4, opcode field width
FUNCT_W, 3, funct field width (passed through to ALU control decode)
TMO_W, 4, width of memory wait counter
MEM_TIMEOUT, 15, max wait cycles per access before FAULT (must fit TMO_W, >=1)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; forces FETCH state and clears counters
opcode  in  OP_W  IR opcode field (valid from DECODE onward)
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access in progress; held until mem_ready or timeout
mem_read, mem_write  out  1 each  access type qualifiers, valid with mem_req
mem_src  out  1  memory address select: 0=PC, 1=ALUOut
ir_write, pc_write, reg_write, out_write  out  1 each  single-cycle write enables
branch_eq, branch_ne  out  1 each  conditional PC write qualifiers (with ALU zero)
src_a  out  1  0=PC, 1=A
src_b  out  2  0=B, 1=const 1, 2=sign-extended imm
alu_op  out  3  0=add, 1=sub, 2=funct-decoded
pc_src  out  2  0=ALU, 1=jump imm, 2=ALUOut
mem_to_reg  out  2  0=MDR, 1=ALUOut, 2=in port
reg_dest  out  2  0=rt, 1=rd, 2=r3
state  out  4  current state encoding (debug)
fault  out  1  sticky; set on illegal opcode or memory timeout
halted  out  1  high in HALT or FAULT

Behaviour:
- Reset (async): state=FETCH, wait counter=0, fault=0. All enables are 0. All selects are 0, except mem_req=1 combinationally in FETCH.
- Outputs are a Moore decode of state. Unlisted signals are 0 in each state.
- FETCH: mem_req=1, mem_read=1, mem_src=0. On mem_ready: ir_write=1, pc_write=1, src_a=0, src_b=1, alu_op=0, pc_src=0, then go to DECODE. ir_write/pc_write are gated by mem_ready in this state only.
- DECODE: src_a=0, src_b=2, alu_op=0 (branch target into ALUOut). Next state by opcode: 0 R→EXEC_R; 1 ADDI→EXEC_I; 2 LW / 3 SW→MEM_ADDR; 4 BEQ / 5 BNE→BRANCH; 6 J→JUMP; 7 IN→IN_WB; 8 OUT→OUT_WR; F HALT→HALT; others→FAULT with fault=1.
- EXEC_R: src_a=1, src_b=0, alu_op=2 → RWB (reg_write, reg_dest=1, mem_to_reg=1) → FETCH.
- EXEC_I: src_a=1, src_b=2, alu_op=0 → IWB (reg_write, reg_dest=0, mem_to_reg=1) → FETCH.
- MEM_ADDR: src_a=1, src_b=2, alu_op=0. Then MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req, mem_read, mem_src=1. Waits for mem_ready → MEM_WB (reg_write, reg_dest=0, mem_to_reg=0) → FETCH.
- MEM_WR: mem_req, mem_write, mem_src=1. Waits for mem_ready → FETCH.
- BRANCH: src_a=1, src_b=0, alu_op=1, pc_src=2, branch_eq (op 4) or branch_ne (op 5) → FETCH.
- JUMP: pc_write, pc_src=1 → FETCH.
- IN_WB: reg_write, reg_dest=2, mem_to_reg=2 → FETCH.
- OUT_WR: out_write → FETCH.
- Wait counter: cleared on entering any memory state. It increments each cycle mem_req=1 and mem_ready=0. When count reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT and set fault=1. If mem_ready arrives on that same cycle, mem_ready wins.
- Zero-wait memory (mem_ready=1 on first cycle) costs one cycle per access. The counter never wraps.
- HALT and FAULT are absorbing states: all enables 0, mem_req=0. Only reset exits them.
- mem_ready outside mem_req is ignored.

Optional Feature:
Macro MC_SEQUENCER_SINGLE_STEP_EN.
- Defined: adds input step (1-bit). Entering FETCH holds in a STEP_WAIT pre-state with mem_req=0 until step=1 for one cycle. One instruction runs per step pulse. A step held high runs continuously. Reset returns to STEP_WAIT.
- Undefined: no step port and no STEP_WAIT state; FETCH runs back-to-back.

Decomposition:
- Package mc_pkg holds:
  - state enum (4-bit)
  - opcode constants (OP_R=0 … OP_HALT=15)
  - alu_op, src_b, pc_src, mem_to_reg and reg_dest select constants
- Natural sub-module: mc_mem_waiter, which holds the wait counter and timeout compare (inputs mem_req, mem_ready, start; output done, timeout).

Test Plan:
- Reset mid-MEM_RD with mem_req=1 → next sampled edge shows state=FETCH, fault=0, all enables 0, mem_req=1.
- ADD (op 0), mem_ready always 1 → state path FETCH,DECODE,EXEC_R,RWB. reg_write=1 with reg_dest=1 on the 4th cycle only. Total 4 cycles.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM_RD → 4 cycles spent in each memory state; ir_write pulses once; MEM_WB reg_write with mem_to_reg=0.
- mem_ready held 0 in MEM_WR, MEM_TIMEOUT=15 → FAULT after 15 wait cycles, fault=1, halted=1. mem_ready asserted exactly at cycle 15 → FETCH instead.
- Opcode 0xB → DECODE→FAULT, fault sticky across 10 cycles. Opcode 0xF → HALT with fault=0, halted=1.
- BEQ vs BNE → branch_eq=1 / branch_ne=1 respectively in BRANCH with alu_op=1, pc_src=2. With the macro defined, no FETCH occurs until step pulses.
